// File: rtl/detect_pkg.sv
// Shared types and constants for the detectinator foreground detector.
package detect_pkg;

  localparam int LUMA_W = 8;
  localparam int S1_W   = 16;

  localparam logic [S1_W-1:0] COEF_R = 16'd77;
  localparam logic [S1_W-1:0] COEF_G = 16'd150;
  localparam logic [S1_W-1:0] COEF_B = 16'd29;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // Weighted sum of 255 in every channel is 256*255, so 16 bits never overflow.
  function automatic logic [S1_W-1:0] luma_sum(input pixel_t p);
    return S1_W'(p.r) * COEF_R + S1_W'(p.g) * COEF_G + S1_W'(p.b) * COEF_B;
  endfunction

endpackage

// File: rtl/detect_luma_thresh.sv
// Two-stage luma conversion and threshold: weighted sum register, then binary mask register.
module luma_thresh
  import detect_pkg::*;
#(
  parameter logic [LUMA_W-1:0] THRESH = 8'd128,
  parameter bit                INVERT = 1'b0
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   en_i,
  input  pixel_t pixel_i,
  output logic   bin_o
);

  logic [S1_W-1:0] s1_d, s1_q;
  logic            bin_d, bin_q;

  always_comb begin
    s1_d  = luma_sum(pixel_i);
    bin_d = (s1_q[S1_W-1 -: LUMA_W] >= THRESH) ^ INVERT;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q  <= '0;
      bin_q <= 1'b0;
    end else if (en_i) begin
      s1_q  <= s1_d;
      bin_q <= bin_d;
    end
  end

  assign bin_o = bin_q;

endmodule

// File: rtl/detect_top.sv
// Streaming foreground detector: luma threshold followed by a 3-tap in-row majority filter.
module detect_top
  import detect_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int THRESH = 128,
  parameter bit INVERT = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [31:0] DATA,
  output logic        OUT
);

  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);

  pixel_t           pixel;
  logic             bin;
  logic [COL_W-1:0] cnt_d, cnt_q;
  logic [COL_W-1:0] s1_col_q, bcol_q;
  logic             w0_q, w1_q, out_q;
  logic             w0m, w1m, out_d;
  logic             unused_alpha;

  assign pixel        = pixel_t'(DATA[23:0]);
  assign unused_alpha = ^DATA[31:24];

  luma_thresh #(
    .THRESH (LUMA_W'(THRESH)),
    .INVERT (INVERT)
  ) u_luma_thresh (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .en_i    (ENABLE),
    .pixel_i (pixel),
    .bin_o   (bin)
  );

  // Taps reaching back past column 0 belong to the previous row and are masked off.
  always_comb begin
    cnt_d = (cnt_q == COL_LAST) ? '0 : cnt_q + COL_W'(1);
    w0m   = w0_q & (bcol_q >= COL_W'(1));
    w1m   = w1_q & (bcol_q >= COL_W'(2));
    out_d = (bin & w0m) | (bin & w1m) | (w0m & w1m);
  end

  // The column travels alongside the pixel so bcol_q always labels the pixel held in bin.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt_q    <= '0;
      s1_col_q <= '0;
      bcol_q   <= '0;
      w0_q     <= 1'b0;
      w1_q     <= 1'b0;
      out_q    <= 1'b0;
    end else if (ENABLE) begin
      cnt_q    <= cnt_d;
      s1_col_q <= cnt_q;
      bcol_q   <= s1_col_q;
      w1_q     <= w0_q;
      w0_q     <= bin;
      out_q    <= out_d;
    end
  end

  assign OUT = out_q;

endmodule

// File: tb/tb_detect_top.sv
// Bench for detect_top: three configurations share one stimulus stream and a pixel-history model.
module tb_detect_top;

  localparam logic [31:0] WHITE = 32'h00FF_FFFF;
  localparam logic [31:0] BLACK = 32'h0000_0000;
  localparam logic [31:0] GREEN = 32'h0000_FF00;
  localparam logic [31:0] RED   = 32'h00FF_0000;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] data;
  logic        out_w4, out_w8, out_inv;

  int          checks;
  int          failures;
  int          nbeat;
  logic [31:0] hist[$];
  bit          exp_w4, exp_w8, exp_inv;
  bit          pat4[8];
  bit          pat8[8];
  bit          mrow[8];

  detect_top #(.WIDTH(4), .THRESH(128), .INVERT(1'b0)) u_w4 (
    .CLK(clk), .RESET(rst_n), .ENABLE(en), .DATA(data), .OUT(out_w4)
  );
  detect_top #(.WIDTH(8), .THRESH(128), .INVERT(1'b0)) u_w8 (
    .CLK(clk), .RESET(rst_n), .ENABLE(en), .DATA(data), .OUT(out_w8)
  );
  detect_top #(.WIDTH(8), .THRESH(128), .INVERT(1'b1)) u_inv (
    .CLK(clk), .RESET(rst_n), .ENABLE(en), .DATA(data), .OUT(out_inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit mask_of(input logic [31:0] p, input bit inv);
    int luma;
    luma = (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) / 256;
    return (luma >= 128) ^ inv;
  endfunction

  // Result visible after beat j belongs to pixel j-2; row position is its index modulo the width.
  function automatic bit model_out(input int w, input bit inv);
    int j, k, col, cnt;
    j = nbeat - 1;
    if (j < 2) return 1'b0;
    k   = j - 2;
    col = k % w;
    cnt = int'(mask_of(hist[k], inv));
    if (col >= 1) cnt += int'(mask_of(hist[k-1], inv));
    if (col >= 2) cnt += int'(mask_of(hist[k-2], inv));
    return cnt >= 2;
  endfunction

  task automatic check(input string tag, input logic obs, input bit expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b beat=%0d", tag, obs, expv, nbeat);
    end
  endtask

  task automatic step(input bit r, input bit e, input logic [31:0] d);
    rst_n = r;
    en    = e;
    data  = d;
    @(posedge clk);
    #1;
    if (!r) begin
      hist.delete();
      nbeat   = 0;
      exp_w4  = 1'b0;
      exp_w8  = 1'b0;
      exp_inv = 1'b0;
    end else if (e) begin
      hist.push_back(d);
      nbeat++;
      exp_w4  = model_out(4, 1'b0);
      exp_w8  = model_out(8, 1'b0);
      exp_inv = model_out(8, 1'b1);
    end
    check("out_w4", out_w4, exp_w4);
    check("out_w8", out_w8, exp_w8);
    check("out_inv", out_inv, exp_inv);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    nbeat    = 0;
    exp_w4   = 1'b0;
    exp_w8   = 1'b0;
    exp_inv  = 1'b0;
    pat4 = '{0, 1, 1, 1, 0, 1, 1, 1};
    pat8 = '{0, 0, 1, 0, 0, 0, 1, 1};
    mrow = '{1, 0, 1, 0, 0, 1, 1, 0};

    // Reset held with live white input, then the two fill beats.
    step(1'b0, 1'b1, WHITE);
    check("rst_out_w4", out_w4, 1'b0);
    step(1'b0, 1'b1, WHITE);
    check("rst_out_w8", out_w8, 1'b0);
    step(1'b1, 1'b1, WHITE);
    check("fill0_w4", out_w4, 1'b0);
    step(1'b1, 1'b1, WHITE);
    check("fill1_w4", out_w4, 1'b0);

    // White rows on the 4-wide instance restart the window at column 0.
    step(1'b0, 1'b1, WHITE);
    for (int j = 0; j < 10; j++) begin
      step(1'b1, 1'b1, WHITE);
      if (j >= 2) check("white_w4_pat", out_w4, pat4[j-2]);
    end

    // Colour rows.
    step(1'b0, 1'b1, BLACK);
    for (int j = 0; j < 10; j++) begin
      step(1'b1, 1'b1, GREEN);
      if (j >= 3) check("green_w8", out_w8, 1'b1);
    end
    step(1'b0, 1'b1, BLACK);
    for (int j = 0; j < 10; j++) begin
      step(1'b1, 1'b1, RED);
      if (j >= 2) check("red_w8", out_w8, 1'b0);
      if (j >= 3) check("red_inv", out_inv, 1'b1);
    end

    // Majority filter on a mixed mask row.
    step(1'b0, 1'b1, BLACK);
    for (int j = 0; j < 10; j++) begin
      step(1'b1, 1'b1, (j < 8 && mrow[j]) ? WHITE : BLACK);
      if (j >= 2) check("maj_w8_pat", out_w8, pat8[j-2]);
    end

    // Stall mid-row: results match the unstalled white sequence.
    step(1'b0, 1'b1, BLACK);
    begin
      int got;
      got = 0;
      for (int j = 0; j < 14; j++) begin
        bit e;
        e = !(j == 4 || j == 5 || j == 9 || j == 10);
        step(1'b1, e, e ? WHITE : BLACK);
        if (e) got++;
        if (got >= 3) check("stall_w4_pat", out_w4, pat4[got-3]);
      end
    end

    // Reset mid-row at column 2.
    step(1'b0, 1'b1, BLACK);
    step(1'b1, 1'b1, WHITE);
    step(1'b1, 1'b1, WHITE);
    step(1'b1, 1'b1, WHITE);
    step(1'b0, 1'b1, WHITE);
    check("midrst_w8", out_w8, 1'b0);
    for (int j = 0; j < 6; j++) begin
      step(1'b1, 1'b1, WHITE);
      if (j == 2) check("midrst_col0_w8", out_w8, 1'b0);
      if (j == 3) check("midrst_col1_w8", out_w8, 1'b1);
    end

    // Random pixels, enables and occasional resets.
    for (int j = 0; j < 600; j++) begin
      bit r, e;
      r = ($urandom_range(0, 99) != 0);
      e = ($urandom_range(0, 9) < 8);
      step(r, e, $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
